// File: rtl/sram_dp_bwe_param_pkg.sv
// Shared definitions for the parametrised dual-port SRAM model.
//   sram_state_t     : init sequencer states
//   RW_READ_FIRST / RW_WRITE_FIRST : read-during-write mode encodings
//   lane_merge()     : byte-lane write merge used by the write path
package sram_model_pkg;

  typedef enum logic {ST_INIT, ST_READY} sram_state_t;

  localparam int RW_READ_FIRST  = 0;
  localparam int RW_WRITE_FIRST = 1;

  // One byte lane: take the new byte when its enable is set, else keep the old one.
  function automatic logic [7:0] lane_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       we);
    return we ? new_b : old_b;
  endfunction

endpackage

// File: rtl/sram_dp_bwe_param_if.sv
// Bus bundle for both SRAM ports plus the status outputs.
//   master : request side (drives en/wea/addr/wdata, observes results)
//   slave  : the memory (drives rdata/rvalid/oor/collide/init_busy)
interface sram_dp_bwe_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic                  en0,    en1;
  logic [DATA_W/8-1:0]   wea0,   wea1;
  logic [ADDR_W-1:0]     addr0,  addr1;
  logic [DATA_W-1:0]     wdata0, wdata1;
  logic [DATA_W-1:0]     rdata0, rdata1;
  logic                  rvalid0, rvalid1;
  logic                  oor0,   oor1;
  logic                  collide;
  logic                  init_busy;

  modport master (
    output en0, wea0, addr0, wdata0, en1, wea1, addr1, wdata1,
    input  rdata0, rvalid0, oor0, rdata1, rvalid1, oor1, collide, init_busy
  );

  modport slave (
    input  en0, wea0, addr0, wdata0, en1, wea1, addr1, wdata1,
    output rdata0, rvalid0, oor0, rdata1, rvalid1, oor1, collide, init_busy
  );
endinterface

// File: rtl/sram_dp_bwe_param_rd_pipe.sv
// Read-return pipeline for one port: RD_LAT stages of {valid, oor, data}.
//   in_valid/in_oor/in_data   : result of the access accepted this cycle
//   out_valid/out_oor/out_data: the same result RD_LAT cycles later
// Data stages only load behind a valid entry, so out_data keeps the last
// returned word while out_valid is low.
module sram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_oor,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_oor,
  output logic [DATA_W-1:0] out_data
);
  logic              valid_reg [RD_LAT];
  logic              oor_reg   [RD_LAT];
  logic [DATA_W-1:0] data_reg  [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        valid_reg[i] <= 1'b0;
        oor_reg[i]   <= 1'b0;
        data_reg[i]  <= '0;
      end
    end else begin
      valid_reg[0] <= in_valid;
      oor_reg[0]   <= in_valid & in_oor;
      if (in_valid) data_reg[0] <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        oor_reg[i]   <= oor_reg[i-1];
        if (valid_reg[i-1]) data_reg[i] <= data_reg[i-1];
      end
    end
  end

  assign out_valid = valid_reg[RD_LAT-1];
  assign out_oor   = oor_reg[RD_LAT-1];
  assign out_data  = data_reg[RD_LAT-1];
endmodule

// File: rtl/sram_dp_bwe_param.sv
// Parametrised true-dual-port SRAM model with byte-lane write enables.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : both ports (en/wea/addr/wdata in, rdata/rvalid/oor out),
//              collide pulse and init_busy status
// Holds the array, the post-reset clear sequencer, the per-lane write merge
// with cross-port collision resolution, and the collide register.
module sram_dp_bwe_param
  import sram_model_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 480,
  parameter int ADDR_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int RW_MODE   = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_dp_bwe_param_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Range check is done on the full address, one bit wider so DEPTH itself fits.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  sram_state_t      state_reg, state_next;
  logic [IDX_W-1:0] init_cnt_reg, init_cnt_next;
  logic             collide_reg, collide_next;

  logic              ready, acc0, acc1, inr0, inr1, w0, w1, same_addr;
  logic [IDX_W-1:0]  idx0, idx1;
  logic [DATA_W-1:0] old0, old1, merged0, merged1, post0, post1, rd0, rd1;

  assign ready     = (state_reg == ST_READY);
  assign acc0      = ready & bus.en0;
  assign acc1      = ready & bus.en1;
  assign inr0      = ({1'b0, bus.addr0} < DEPTH_L);
  assign inr1      = ({1'b0, bus.addr1} < DEPTH_L);
  assign w0        = acc0 & inr0 & (|bus.wea0);
  assign w1        = acc1 & inr1 & (|bus.wea1);
  assign same_addr = (bus.addr0 == bus.addr1);
  assign idx0      = bus.addr0[IDX_W-1:0];
  assign idx1      = bus.addr1[IDX_W-1:0];

  // Index only when in range; out-of-range slices of the address never reach the array.
  assign old0 = inr0 ? mem[idx0] : '0;
  assign old1 = inr1 ? mem[idx1] : '0;

  // merged0 is the final word for addr0: port 0 lanes first, then any lanes
  // only port 1 enables at the same address. merged1 is port 1 alone.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign merged0[8*gi +: 8] = (w1 && same_addr && !bus.wea0[gi])
                                ? lane_merge(old0[8*gi +: 8], bus.wdata1[8*gi +: 8], bus.wea1[gi])
                                : lane_merge(old0[8*gi +: 8], bus.wdata0[8*gi +: 8], bus.wea0[gi]);
      assign merged1[8*gi +: 8] = lane_merge(old1[8*gi +: 8], bus.wdata1[8*gi +: 8], bus.wea1[gi]);
    end
  endgenerate

  // Post-write view of each port's address, whichever port(s) wrote it.
  assign post0 = w0 ? merged0 : ((same_addr && w1) ? merged1 : old0);
  assign post1 = (same_addr && w0) ? merged0 : (w1 ? merged1 : old1);

  assign rd0 = !inr0 ? '0 : ((RW_MODE == RW_WRITE_FIRST) ? post0 : old0);
  assign rd1 = !inr1 ? '0 : ((RW_MODE == RW_WRITE_FIRST) ? post1 : old1);

  // When both ports hit the same word, merged0 already carries both, so port 1 stands down.
  always_ff @(posedge clk) begin
    if (state_reg == ST_INIT) begin
      mem[init_cnt_reg] <= '0;
    end else begin
      if (w0) mem[idx0] <= merged0;
      if (w1 && !(w0 && same_addr)) mem[idx1] <= merged1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
      init_cnt_reg <= '0;
      collide_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
      collide_reg  <= collide_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    collide_next  = w0 & w1 & same_addr & (|(bus.wea0 & bus.wea1));
    case (state_reg)
      ST_INIT: begin
        init_cnt_next = init_cnt_reg + 1'b1;
        if (init_cnt_reg == IDX_W'(DEPTH - 1)) begin
          state_next    = ST_READY;
          init_cnt_next = '0;
        end
      end
      default: ;
    endcase
  end

  assign bus.init_busy = (state_reg == ST_INIT);
  assign bus.collide   = collide_reg;

  sram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe0 (
    .clk(clk), .rst(rst), .in_valid(acc0), .in_oor(~inr0), .in_data(rd0),
    .out_valid(bus.rvalid0), .out_oor(bus.oor0), .out_data(bus.rdata0)
  );

  sram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe1 (
    .clk(clk), .rst(rst), .in_valid(acc1), .in_oor(~inr1), .in_data(rd1),
    .out_valid(bus.rvalid1), .out_oor(bus.oor1), .out_data(bus.rdata1)
  );
endmodule
